// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: accepts a, b over valid/ready, resolves one bit per
// clock LSB-first through a borrow flop, and presents diff = a - b and the final borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             ai;
  logic             bi;
  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // Handshakes: a transfer happens on the rising edge where valid and ready are both
  // high; ready and valid are decoded from state only, never from the partner's signal.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign ai       = a_sh[0];
  assign bi       = b_sh[0];
  assign d        = ai ^ bi ^ br;
  assign br_next  = (~ai & bi) | (~(ai ^ bi) & br);
  assign res_next = {d, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          br     <= br_next;
          cnt    <= cnt + 1'b1;
          // Last bit: publish the completed word together with the final borrow.
          if (cnt == CW'(WIDTH - 1)) begin
            diff   <= res_next;
            borrow <= br_next;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized bench for serial_subtractor (WIDTH=8), inline checks per task.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] diff;
  logic       borrow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Present one operand pair for a single edge; the caller guarantees the block is idle.
  task automatic send(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  // Count edges until out_valid rises, bounded at 50.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b diff=%h borrow=%b, need 1 0 0 00 0",
               in_ready, out_valid, busy, diff, borrow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int cyc;
    out_ready = 1'b1;
    send(8'h35, 8'h12);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b in_ready=%b, need 1 0", busy, in_ready);
    end
    wait_out(cyc);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, need 8", cyc);
    end
    checks++;
    if (diff !== 8'h23 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: diff=%h borrow=%b, need 23 0", diff, borrow);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_return: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors;
    logic [7:0] va [3] = '{8'h12, 8'h00, 8'hAA};
    logic [7:0] vb [3] = '{8'h35, 8'h01, 8'hAA};
    logic [7:0] ed [3] = '{8'hDD, 8'hFF, 8'h00};
    logic       eb [3] = '{1'b1, 1'b1, 1'b0};
    int cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(va[i], vb[i]);
      wait_out(cyc);
      checks++;
      if (cyc !== 8 || diff !== ed[i] || borrow !== eb[i]) begin
        errors++;
        $display("FAIL vector_%0d: cyc=%0d diff=%h borrow=%b, need 8 %h %b",
                 i, cyc, diff, borrow, ed[i], eb[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    out_ready = 1'b0;
    send(8'hF0, 8'h0F);
    wait_out(cyc);
    checks++;
    if (cyc !== 8) begin
      errors++;
      $display("FAIL bp_latency: got %0d cycles, need 8", cyc);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || diff !== 8'hE1 || borrow !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: out_valid=%b diff=%h borrow=%b in_ready=%b, need 1 e1 0 0",
                 i, out_valid, diff, borrow, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, need 0 1 0", out_valid, in_ready, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== 8'hE1) begin
      errors++;
      $display("FAIL bp_single: out_valid=%b diff=%h, need 0 e1", out_valid, diff);
    end
  endtask

  task automatic test_ignored_input;
    int cyc;
    int bad;
    out_ready = 1'b1;
    send(8'h80, 8'h01);
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    cyc = 0;
    bad = 0;
    while (!out_valid && cyc < 50) begin
      if (in_ready !== 1'b0) bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0 || cyc !== 8) begin
      errors++;
      $display("FAIL ignore_ready: in_ready high %0d times, cyc=%0d, need 0 and 8", bad, cyc);
    end
    checks++;
    if (diff !== 8'h7F || borrow !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: diff=%h borrow=%b, need 7f 0", diff, borrow);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    out_ready = 1'b1;
    send(8'h55, 8'h22);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b busy=%b diff=%h borrow=%b, need 1 0 0 00 0",
               in_ready, out_valid, busy, diff, borrow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h02, 8'h03);
    wait_out(cyc);
    checks++;
    if (cyc !== 8 || diff !== 8'hFF || borrow !== 1'b1) begin
      errors++;
      $display("FAIL midrun_after: cyc=%0d diff=%h borrow=%b, need 8 ff 1", cyc, diff, borrow);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int cyc;
    int stall;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] exp_d;
    logic       exp_b;
    for (int n = 0; n < 1000; n++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      if (n % 8 == 0) y = x;
      exp_d = x - y;
      exp_b = (x < y);
      stall = $urandom_range(0, 3);
      out_ready = (stall == 0);
      send(x, y);
      wait_out(cyc);
      checks++;
      if (cyc !== 8 || diff !== exp_d || borrow !== exp_b) begin
        errors++;
        $display("FAIL sweep_%0d: a=%h b=%h cyc=%0d diff=%h borrow=%b, need 8 %h %b",
                 n, x, y, cyc, diff, borrow, exp_d, exp_b);
      end
      for (int s = 0; s < stall; s++) begin
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_ignored_input();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
